// File: rtl/result_serializer_if.sv
// Result-set capture and host byte-stream bundle of the result serializer.
// Master drives the result set and host ack; slave is the serializer.
interface result_serializer_if;
    logic        start;
    logic [2:0]  mode;
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic        host_ack;
    logic        busy;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        done;
    logic        timeout_err;

    modport master (
        output start, mode, word_a, word_b, host_ack,
        input  busy, out_byte, out_valid, done, timeout_err
    );

    modport slave (
        input  start, mode, word_a, word_b, host_ack,
        output busy, out_byte, out_valid, done, timeout_err
    );
endinterface

// File: rtl/result_serializer.sv
// Streams one captured result set as a framed, checksummed byte sequence
// to an off-chip host over a 4-phase ack handshake with a watchdog.
module result_serializer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic                clk,
    input logic                rst,
    result_serializer_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
    } state_t;

    state_t state, state_n;

    logic          ack_m, ack_s;
    logic [2:0]    mode_q, mode_n;
    logic [63:0]   data_q, data_n;
    logic [3:0]    idx, idx_n;
    logic [7:0]    chk, chk_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          busy_q, busy_n;
    logic          valid_q, valid_n;
    logic [7:0]    byte_q, byte_n;
    logic          done_q, done_n;
    logic          terr_q, terr_n;

    logic last, next_is_chk, expired;

    // Degenerate regime (mode 0) frames are header + checksum only.
    assign last        = (mode_q == 3'd0) ? (idx == 4'd1) : (idx == 4'd9);
    assign next_is_chk = (mode_q == 3'd0) ? (idx == 4'd0) : (idx == 4'd8);
    assign expired     = (cnt == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= bus.host_ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= '0;
            data_q  <= '0;
            idx     <= '0;
            chk     <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            mode_q  <= mode_n;
            data_q  <= data_n;
            idx     <= idx_n;
            chk     <= chk_n;
            cnt     <= cnt_n;
            busy_q  <= busy_n;
            valid_q <= valid_n;
            byte_q  <= byte_n;
            done_q  <= done_n;
            terr_q  <= terr_n;
        end
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        data_n  = data_q;
        idx_n   = idx;
        chk_n   = chk;
        cnt_n   = (cnt == '1) ? cnt : cnt + 1'b1;
        busy_n  = busy_q;
        valid_n = valid_q;
        byte_n  = byte_q;
        done_n  = 1'b0;
        terr_n  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n   = '0;
                busy_n  = 1'b0;
                valid_n = 1'b0;
                byte_n  = '0;
                if (bus.start) begin
                    state_n = PRESENT;
                    mode_n  = bus.mode;
                    data_n  = {bus.word_a, bus.word_b};
                    idx_n   = '0;
                    chk_n   = 8'h5A;
                    busy_n  = 1'b1;
                    valid_n = 1'b1;
                    byte_n  = {4'hA, 1'b0, bus.mode};
                end
            end
            PRESENT: begin
                if (ack_s) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    chk_n   = chk ^ byte_q;
                    valid_n = 1'b0;
                    byte_n  = '0;
                end else if (expired) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    terr_n  = 1'b1;
                    busy_n  = 1'b0;
                    valid_n = 1'b0;
                    byte_n  = '0;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    cnt_n = '0;
                    if (last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = PRESENT;
                        idx_n   = idx + 4'd1;
                        valid_n = 1'b1;
                        // Data bytes leave MSB-first from a shift register.
                        if (next_is_chk) begin
                            byte_n = chk;
                        end else begin
                            byte_n = data_q[63:56];
                            data_n = {data_q[55:0], 8'h00};
                        end
                    end
                end else if (expired) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    terr_n  = 1'b1;
                    busy_n  = 1'b0;
                    valid_n = 1'b0;
                    byte_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_byte    = byte_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: frames, checksum, busy-drop,
// watchdog, mid-frame reset and ack synchronizer latency.
module tb_result_serializer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    result_serializer_if bus ();

    result_serializer #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // mode 2, 12345678 / FFFFFFFE
    logic [7:0] f1 [10] = '{8'hA2, 8'h12, 8'h34, 8'h56, 8'h78,
                            8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hF1};
    // mode 1, 01020304 / 00000000
    logic [7:0] f3 [10] = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_start(input logic [2:0] m, input logic [31:0] a,
                              input logic [31:0] b);
        bus.mode   = m;
        bus.word_a = a;
        bus.word_b = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic get_byte(input logic [7:0] exp, input bit inj);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_valid", 32'(bus.out_valid), 32'd1);
        check("byte_value", 32'(bus.out_byte), 32'(exp));
        if (inj) begin
            bus.mode   = 3'b001;
            bus.word_a = 32'h0;
            bus.word_b = 32'h0;
            bus.start  = 1'b1;
            @(negedge clk);
            bus.start  = 1'b0;
            check("busy_drop_byte", 32'(bus.out_byte), 32'(exp));
            check("busy_drop_busy", 32'(bus.busy), 32'd1);
        end
        bus.host_ack = 1'b1;
        n = 0;
        while (bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_byte", 32'(bus.out_byte), 32'd0);
        bus.host_ack = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_terr", 32'(bus.timeout_err), 32'd0);
    endtask

    task automatic run_frame(input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] b,
                             input logic [7:0] e [10], input int nb);
        send_start(m, a, b);
        for (int i = 0; i < nb; i++) get_byte(e[i], 1'b0);
        wait_done();
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int cnt;
        logic [7:0] f2 [10] = '{8'hA0, 8'hFA, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.mode     = 3'd0;
        bus.word_a   = 32'h0;
        bus.word_b   = 32'h0;
        bus.host_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_byte", 32'(bus.out_byte), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_terr", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(3'b010, 32'h1234_5678, 32'hFFFF_FFFE, f1, 10);
        run_frame(3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, f2, 2);

        // start while busy at byte 3, then restart in the done cycle
        send_start(3'b010, 32'h1234_5678, 32'hFFFF_FFFE);
        for (int i = 0; i < 10; i++) get_byte(f1[i], i == 3);
        wait_done();
        send_start(3'b001, 32'h0102_0304, 32'h0000_0000);
        check("restart_done_low", 32'(bus.done), 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 10; i++) get_byte(f3[i], 1'b0);
        wait_done();
        @(negedge clk);

        // watchdog: host silent
        send_start(3'b010, 32'h1234_5678, 32'hFFFF_FFFE);
        cnt = 0;
        while (bus.out_valid && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("wd_valid_cycles", 32'(cnt), 32'd16);
        check("wd_terr", 32'(bus.timeout_err), 32'd1);
        check("wd_busy", 32'(bus.busy), 32'd0);
        check("wd_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("wd_terr_once", 32'(bus.timeout_err), 32'd0);

        // reset while byte 5 presented
        send_start(3'b010, 32'h1234_5678, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) get_byte(f1[i], 1'b0);
        cnt = 0;
        while (!bus.out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_byte5", 32'(bus.out_byte), 32'hFF);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_byte", 32'(bus.out_byte), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_terr", 32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(3'b010, 32'h1234_5678, 32'hFFFF_FFFE, f1, 10);

        // ack synchronizer latency, mid-cycle toggles
        send_start(3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(posedge clk);
        #3 bus.host_ack = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            check("lat_rise_valid", 32'(bus.out_valid), (e < 3) ? 32'd1 : 32'd0);
            check("lat_rise_byte", 32'(bus.out_byte), (e < 3) ? 32'hA0 : 32'h0);
        end
        #3 bus.host_ack = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            check("lat_fall_valid", 32'(bus.out_valid), (e < 3) ? 32'd0 : 32'd1);
            check("lat_fall_byte", 32'(bus.out_byte), (e < 3) ? 32'h0 : 32'hFA);
        end
        @(negedge clk);
        get_byte(8'hFA, 1'b0);
        wait_done();
        @(negedge clk);
        check("lat_done_once", 32'(bus.done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
